// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multicycle RV32I-subset control unit.
//   - state_t      : control FSM states
//   - OP_*         : major opcode values (instr[6:0])
//   - ALU_*        : ALUctl encodings
//   - PC_*         : PCsrc encodings
//   - M2R_*        : MemtoReg encodings
//   - is_legal_op  : true for every opcode the control unit knows how to sequence
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SRA = 3'b111;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  localparam logic [2:0] M2R_ALU   = 3'b000;
  localparam logic [2:0] M2R_MEM   = 3'b001;
  localparam logic [2:0] M2R_PC4   = 3'b010;
  localparam logic [2:0] M2R_IMM   = 3'b011;
  localparam logic [2:0] M2R_PCIMM = 3'b100;
  localparam logic [2:0] M2R_SLT   = 3'b101;

  function automatic logic is_legal_op(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_SYSTEM: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: combinational ALU operation decode for R-type and I-ALU
// instructions. Everything else decodes to add.
//   i_opcode   : instr[6:0]
//   i_funct3   : instr[14:12]
//   i_funct7b5 : instr[30]
//   o_alu_ctl  : ALUctl encoding
//   o_is_slt   : slt/slti, result comes from the ALU sign bit
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  output logic [2:0] o_alu_ctl,
  output logic       o_is_slt
);

  logic w_is_r;

  assign w_is_r = (i_opcode == OP_R);

  always_comb begin
    o_alu_ctl = ALU_ADD;
    o_is_slt  = 1'b0;
    if (w_is_r || (i_opcode == OP_I)) begin
      case (i_funct3)
        // instr[30] is part of the immediate for addi, so only R-type subtracts
        3'b000: o_alu_ctl = (w_is_r && i_funct7b5) ? ALU_SUB : ALU_ADD;
        3'b001: o_alu_ctl = ALU_SLL;
        3'b010: begin
          o_alu_ctl = ALU_SUB;
          o_is_slt  = 1'b1;
        end
        3'b011: o_alu_ctl = ALU_SUB;
        3'b100: o_alu_ctl = ALU_XOR;
        // instr[30] selects arithmetic shift for both sra and srai
        3'b101: o_alu_ctl = i_funct7b5 ? ALU_SRA : ALU_SRL;
        3'b110: o_alu_ctl = ALU_OR;
        default: o_alu_ctl = ALU_AND;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: control FSM for a multicycle RV32I-subset datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB; outputs are decoded from the state
// register plus the current IR fields, so they drop to zero as soon as rst rises.
//   clk, rst             : clock, async active-high reset
//   run                  : start/continue, sampled at instruction boundaries
//   opcode..ebreak_bit   : IR fields
//   ALUzero, ALUneg      : ALU flags for branches and slt
//   IRwrite..MemSize     : datapath strobes and mux selects
//   halted, illegal      : HALT state, sticky illegal-opcode flag
//   instret              : retired instruction count (wraps)
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  input  logic         funct7b5,
  input  logic         ebreak_bit,
  input  logic         ALUzero,
  input  logic         ALUneg,
  output logic         IRwrite,
  output logic         PCwrite,
  output logic         RegWrite,
  output logic         ALUsrc,
  output logic [2:0]   ALUctl,
  output logic [1:0]   PCsrc,
  output logic [2:0]   MemtoReg,
  output logic         MemWrite,
  output logic [1:0]   MemSize,
  output logic         halted,
  output logic         illegal,
  output logic [W-1:0] instret
);

  state_t         r_state;
  state_t         w_state_next;
  logic [W-1:0]   r_instret;
  logic           r_illegal;
  logic           w_retire;
  logic           w_set_illegal;
  logic           w_clr_illegal;
  logic [2:0]     w_dec_alu_ctl;
  logic           w_is_slt;
  logic           w_ex_alusrc;
  logic [2:0]     w_ex_alu_ctl;
  logic           w_taken;
  state_t         w_boundary_next;

  alu_decoder u_alu_decoder (
    .i_opcode   (opcode),
    .i_funct3   (funct3),
    .i_funct7b5 (funct7b5),
    .o_alu_ctl  (w_dec_alu_ctl),
    .o_is_slt   (w_is_slt)
  );

  // ALU setup chosen in EXEC; MEM and WB keep driving it so the datapath sees
  // stable ALU inputs (address for memory, target for jalr, sign for slt).
  always_comb begin
    w_ex_alusrc  = 1'b0;
    w_ex_alu_ctl = ALU_ADD;
    case (opcode)
      OP_R:                      w_ex_alu_ctl = w_dec_alu_ctl;
      OP_I: begin
        w_ex_alusrc  = 1'b1;
        w_ex_alu_ctl = w_dec_alu_ctl;
      end
      OP_LOAD, OP_STORE, OP_JALR: w_ex_alusrc = 1'b1;
      OP_BRANCH:                 w_ex_alu_ctl = ALU_SUB;
      default: ;
    endcase
  end

  // funct3[2] picks the sign test (blt/bge) over the zero test (beq/bne);
  // funct3[0] inverts the sense.
  assign w_taken = funct3[2] ? (ALUneg ^ funct3[0]) : (ALUzero ^ funct3[0]);

  // run is only honoured when an instruction retires
  assign w_boundary_next = run ? S_FETCH : S_IDLE;

  always_comb begin
    w_state_next  = r_state;
    w_retire      = 1'b0;
    w_set_illegal = 1'b0;
    w_clr_illegal = 1'b0;
    IRwrite       = 1'b0;
    PCwrite       = 1'b0;
    RegWrite      = 1'b0;
    ALUsrc        = 1'b0;
    ALUctl        = ALU_ADD;
    PCsrc         = PC_PLUS4;
    MemtoReg      = M2R_ALU;
    MemWrite      = 1'b0;
    MemSize       = 2'b00;
    halted        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) w_state_next = S_FETCH;
      end
      S_FETCH: begin
        IRwrite      = 1'b1;
        w_state_next = S_DECODE;
      end
      S_DECODE: begin
        if (!is_legal_op(opcode)) begin
          w_state_next  = S_HALT;
          w_set_illegal = 1'b1;
        end else if ((opcode == OP_SYSTEM) && ebreak_bit) begin
          w_state_next = S_HALT;
        end else begin
          w_state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        ALUsrc = w_ex_alusrc;
        ALUctl = w_ex_alu_ctl;
        case (opcode)
          OP_BRANCH: begin
            PCwrite      = 1'b1;
            PCsrc        = w_taken ? PC_IMM : PC_PLUS4;
            w_retire     = 1'b1;
            w_state_next = w_boundary_next;
          end
          // ecall has no system to trap into: retire it as a no-op
          OP_SYSTEM: begin
            PCwrite      = 1'b1;
            w_retire     = 1'b1;
            w_state_next = w_boundary_next;
          end
          OP_LOAD, OP_STORE: w_state_next = S_MEM;
          default:           w_state_next = S_WB;
        endcase
      end
      S_MEM: begin
        ALUsrc  = w_ex_alusrc;
        ALUctl  = w_ex_alu_ctl;
        MemSize = funct3[1:0];
        if (opcode == OP_STORE) begin
          MemWrite     = 1'b1;
          PCwrite      = 1'b1;
          w_retire     = 1'b1;
          w_state_next = w_boundary_next;
        end else begin
          w_state_next = S_WB;
        end
      end
      S_WB: begin
        ALUsrc   = w_ex_alusrc;
        ALUctl   = w_ex_alu_ctl;
        RegWrite = 1'b1;
        PCwrite  = 1'b1;
        w_retire = 1'b1;
        if (w_is_slt) begin
          MemtoReg = M2R_SLT;
        end else begin
          case (opcode)
            OP_LOAD:         MemtoReg = M2R_MEM;
            OP_LUI:          MemtoReg = M2R_IMM;
            OP_AUIPC:        MemtoReg = M2R_PCIMM;
            OP_JAL, OP_JALR: MemtoReg = M2R_PC4;
            default:         MemtoReg = M2R_ALU;
          endcase
        end
        case (opcode)
          OP_JAL:  PCsrc = PC_IMM;
          OP_JALR: PCsrc = PC_ALU;
          default: PCsrc = PC_PLUS4;
        endcase
        w_state_next = w_boundary_next;
      end
      S_HALT: begin
        halted = 1'b1;
        // waiting for run to drop forces a fresh rising run to restart
        if (!run) begin
          w_state_next  = S_IDLE;
          w_clr_illegal = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_instret <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_retire) r_instret <= r_instret + 1'b1;
      if (w_set_illegal)      r_illegal <= 1'b1;
      else if (w_clr_illegal) r_illegal <= 1'b0;
    end
  end

  assign instret = r_instret;
  assign illegal = r_illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed self-checking bench for multicycle_control.
// Steps one clock at a time, checks the packed output vector #1 after each
// rising edge against hand-computed values.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        alu_zero = 1'b0;
  logic        alu_neg = 1'b0;

  logic        IRwrite, PCwrite, RegWrite, ALUsrc, MemWrite, halted, illegal;
  logic [2:0]  ALUctl, MemtoReg;
  logic [1:0]  PCsrc, MemSize;
  logic [31:0] instret;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_control #(.W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .opcode     (instr[6:0]),
    .funct3     (instr[14:12]),
    .funct7b5   (instr[30]),
    .ebreak_bit (instr[20]),
    .ALUzero    (alu_zero),
    .ALUneg     (alu_neg),
    .IRwrite    (IRwrite),
    .PCwrite    (PCwrite),
    .RegWrite   (RegWrite),
    .ALUsrc     (ALUsrc),
    .ALUctl     (ALUctl),
    .PCsrc      (PCsrc),
    .MemtoReg   (MemtoReg),
    .MemWrite   (MemWrite),
    .MemSize    (MemSize),
    .halted     (halted),
    .illegal    (illegal),
    .instret    (instret)
  );

  // {IRwrite,PCwrite,RegWrite,ALUsrc,ALUctl[3],PCsrc[2],MemtoReg[3],MemWrite,MemSize[2],halted,illegal}
  logic [16:0] obs;
  assign obs = {IRwrite, PCwrite, RegWrite, ALUsrc, ALUctl, PCsrc, MemtoReg,
                MemWrite, MemSize, halted, illegal};

  localparam logic [16:0] V_ZERO  = 17'h00000;
  localparam logic [16:0] V_FETCH = 17'h10000;
  localparam logic [16:0] V_HALT  = 17'h00002;
  localparam logic [16:0] V_ILL   = 17'h00003;

  function automatic logic [16:0] ex(input logic pcw, input logic asrc,
                                     input logic [2:0] actl, input logic [1:0] pcs);
    return {1'b0, pcw, 1'b0, asrc, actl, pcs, 3'b000, 1'b0, 2'b00, 2'b00};
  endfunction

  function automatic logic [16:0] wb(input logic asrc, input logic [2:0] actl,
                                     input logic [1:0] pcs, input logic [2:0] m2r);
    return {1'b0, 1'b1, 1'b1, asrc, actl, pcs, m2r, 1'b0, 2'b00, 2'b00};
  endfunction

  function automatic logic [16:0] mem(input logic pcw, input logic mw, input logic [1:0] ms);
    return {1'b0, pcw, 1'b0, 1'b1, 3'b000, 2'b00, 3'b000, mw, ms, 2'b00};
  endfunction

  task automatic chk_vec(input string tag, input logic [16:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s outputs observed %05h expected %05h", tag, obs, exp);
    end
    $display("step %-14s outputs %05h instret %0d", tag, obs, instret);
  endtask

  task automatic cyc(input string tag, input logic [16:0] exp);
    @(posedge clk);
    #1;
    chk_vec(tag, exp);
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] exp);
    checks++;
    assert (instret === exp) else begin
      errors++;
      $error("FAIL %s instret observed %0d expected %0d", tag, instret, exp);
    end
  endtask

  // enter FETCH, then present the next instruction word as the IR contents
  task automatic fetch(input string tag, input logic [31:0] ins);
    cyc(tag, V_FETCH);
    instr = ins;
  endtask

  initial begin
    #2 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_vec("reset", V_ZERO);
    chk_cnt("reset_cnt", 32'd0);
    rst = 1'b0;
    run = 1'b1;

    // add
    fetch("add_F", 32'h00000033);
    cyc("add_D", V_ZERO);
    cyc("add_EX", ex(1'b0, 1'b0, 3'b000, 2'b00));
    cyc("add_WB", wb(1'b0, 3'b000, 2'b00, 3'b000));
    // sub
    fetch("sub_F", 32'h40000033);
    chk_cnt("add_ret", 32'd1);
    cyc("sub_D", V_ZERO);
    cyc("sub_EX", ex(1'b0, 1'b0, 3'b001, 2'b00));
    cyc("sub_WB", wb(1'b0, 3'b001, 2'b00, 3'b000));
    // srai
    fetch("srai_F", 32'h40005013);
    cyc("srai_D", V_ZERO);
    cyc("srai_EX", ex(1'b0, 1'b1, 3'b111, 2'b00));
    cyc("srai_WB", wb(1'b1, 3'b111, 2'b00, 3'b000));
    // addi with instr[30]=1 must still add
    fetch("addi_F", 32'h40000013);
    cyc("addi_D", V_ZERO);
    cyc("addi_EX", ex(1'b0, 1'b1, 3'b000, 2'b00));
    cyc("addi_WB", wb(1'b1, 3'b000, 2'b00, 3'b000));
    // lw: 5 cycles
    fetch("lw_F", 32'h00002003);
    chk_cnt("addi_ret", 32'd4);
    cyc("lw_D", V_ZERO);
    cyc("lw_EX", ex(1'b0, 1'b1, 3'b000, 2'b00));
    cyc("lw_MEM", mem(1'b0, 1'b0, 2'b10));
    cyc("lw_WB", wb(1'b1, 3'b000, 2'b00, 3'b001));
    // sb: 4 cycles, no RegWrite
    fetch("sb_F", 32'h00000023);
    cyc("sb_D", V_ZERO);
    cyc("sb_EX", ex(1'b0, 1'b1, 3'b000, 2'b00));
    cyc("sb_MEM", mem(1'b1, 1'b1, 2'b00));
    // beq taken
    fetch("beqT_F", 32'h00000063);
    chk_cnt("sb_ret", 32'd6);
    alu_zero = 1'b1;
    cyc("beqT_D", V_ZERO);
    cyc("beqT_EX", ex(1'b1, 1'b0, 3'b001, 2'b01));
    // beq not taken
    fetch("beqN_F", 32'h00000063);
    alu_zero = 1'b0;
    cyc("beqN_D", V_ZERO);
    cyc("beqN_EX", ex(1'b1, 1'b0, 3'b001, 2'b00));
    // blt with ALUneg=1 taken
    fetch("blt_F", 32'h00004063);
    alu_neg = 1'b1;
    cyc("blt_D", V_ZERO);
    cyc("blt_EX", ex(1'b1, 1'b0, 3'b001, 2'b01));
    // bge with ALUneg=1 not taken
    fetch("bge_F", 32'h00005063);
    cyc("bge_D", V_ZERO);
    cyc("bge_EX", ex(1'b1, 1'b0, 3'b001, 2'b00));
    // jal
    fetch("jal_F", 32'h0000006F);
    chk_cnt("br_ret", 32'd10);
    alu_neg = 1'b0;
    cyc("jal_D", V_ZERO);
    cyc("jal_EX", V_ZERO);
    cyc("jal_WB", wb(1'b0, 3'b000, 2'b01, 3'b010));
    // jalr
    fetch("jalr_F", 32'h00000067);
    cyc("jalr_D", V_ZERO);
    cyc("jalr_EX", ex(1'b0, 1'b1, 3'b000, 2'b00));
    cyc("jalr_WB", wb(1'b1, 3'b000, 2'b10, 3'b010));
    // lui
    fetch("lui_F", 32'h00000037);
    cyc("lui_D", V_ZERO);
    cyc("lui_EX", V_ZERO);
    cyc("lui_WB", wb(1'b0, 3'b000, 2'b00, 3'b011));
    // slt, then pause at its boundary
    fetch("slt_F", 32'h00002033);
    cyc("slt_D", V_ZERO);
    cyc("slt_EX", ex(1'b0, 1'b0, 3'b001, 2'b00));
    cyc("slt_WB", wb(1'b0, 3'b001, 2'b00, 3'b101));
    run = 1'b0;
    cyc("pause_IDLE", V_ZERO);
    cyc("pause_hold", V_ZERO);
    chk_cnt("pause_cnt", 32'd14);
    run = 1'b1;
    // ebreak
    fetch("ebrk_F", 32'h00100073);
    cyc("ebrk_D", V_ZERO);
    cyc("ebrk_HALT", V_HALT);
    cyc("ebrk_stay", V_HALT);
    chk_cnt("ebrk_cnt", 32'd14);
    run = 1'b0;
    cyc("ebrk_IDLE", V_ZERO);
    run = 1'b1;
    // illegal opcode
    fetch("ill_F", 32'h0000007F);
    cyc("ill_D", V_ZERO);
    cyc("ill_HALT", V_ILL);
    cyc("ill_stay", V_ILL);
    run = 1'b0;
    cyc("ill_IDLE", V_ZERO);
    run = 1'b1;
    // reset in the middle of a load's MEM cycle
    fetch("rst_F", 32'h00002003);
    cyc("rst_D", V_ZERO);
    cyc("rst_EX", ex(1'b0, 1'b1, 3'b000, 2'b00));
    cyc("rst_MEM", mem(1'b0, 1'b0, 2'b10));
    #2 rst = 1'b1;
    #1;
    chk_vec("async_rst", V_ZERO);
    chk_cnt("async_cnt", 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multicycle control FSM that sequences the RV32I-subset datapath: fetch, decode, execute, memory, write-back.
- Decodes opcode/funct3/funct7[5] from the datapath's instruction register.
- Drives RegWrite, ALUsrc, ALUctl, PCsrc, MemtoReg and memory/PC/IR strobes.
- Evaluates branches from ALUzero/ALUneg, starts on run, stops on ebreak or an illegal opcode.

Parameters:
W, 32, datapath word width (retired-instruction counter width)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
run  in  1  level; start/continue execution
opcode  in  7  instr[6:0] from IR
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
ebreak_bit  in  1  instr[20] (distinguishes ebreak from ecall)
ALUzero  in  1  ALU result == 0
ALUneg  in  1  ALU result sign bit
IRwrite  out  1  load IR from im_data
PCwrite  out  1  update PC from PCsrc mux
RegWrite  out  1  register-file write enable
ALUsrc  out  1  0=rs2, 1=immediate
ALUctl  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 sll, 110 srl, 111 sra
PCsrc  out  2  00 PC+4, 01 PC+imm, 10 ALU result (jalr, LSB cleared in datapath), 11 reserved
MemtoReg  out  3  000 ALU, 001 dm_data_out, 010 PC+4, 011 imm, 100 PC+imm, 101 {0,ALUneg}
MemWrite  out  1  data-memory write strobe
MemSize  out  2  00 byte, 01 half, 10 word (= funct3[1:0])
halted  out  1  in HALT state
illegal  out  1  sticky; set when halting on unknown opcode
instret  out  W  retired-instruction count

Behaviour:
- Reset (async): state=IDLE, instret=0, illegal=0. All strobes 0, ALUctl=000, PCsrc=00, MemtoReg=000, MemSize=00.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. State is registered; outputs are Moore-decoded from state plus current IR fields.
- IDLE: run=1 -> FETCH; otherwise stay.
- FETCH: IRwrite=1 -> DECODE.
- DECODE: illegal opcode -> HALT, set illegal. ebreak (opcode 1110011, ebreak_bit=1) -> HALT, no PC update. Else -> EXEC.
- EXEC, R-type (0110011):
  - ALUsrc=0.
  - ALUctl from funct3/funct7b5: add/sub, and, or, xor, sll, srl/sra.
  - slt: ALUctl=sub.
- EXEC, I-ALU (0010011): ALUsrc=1, same decode. funct7b5 is honoured only for srai; addi never subtracts.
- EXEC, load/store: ALUsrc=1, ALUctl=add -> MEM.
- EXEC, branch (1100011):
  - ALUsrc=0, ALUctl=sub, PCwrite=1.
  - taken: beq ALUzero; bne !ALUzero; blt ALUneg; bge !ALUneg.
  - PCsrc=01 if taken, else 00. -> FETCH; instret increments.
- EXEC, lui/auipc/jal: no ALU use -> WB.
- EXEC, jalr: ALUsrc=1, ALUctl=add -> WB.
- MEM, load: ALU address held, MemSize driven -> WB.
- MEM, store: MemWrite=1, PCwrite=1, PCsrc=00, instret++ -> FETCH.
- WB:
  - RegWrite=1, PCwrite=1, instret++.
  - MemtoReg: slt/slti 101, load 001, lui 011, auipc 100, jal/jalr 010, else 000.
  - PCsrc: jal 01, jalr 10 (ALU inputs held from EXEC), else 00.
  - Next: FETCH if run=1, else IDLE.
- Pause: run sampled only at instruction boundaries (WB exit, end of branch/store). When run=0 there, the next state is IDLE instead of FETCH; an in-flight instruction always completes.
- HALT: all strobes 0, halted=1. run=0 -> IDLE, clearing illegal. run must drop and rise again to restart.
- CPI: branch 3; ALU/lui/auipc/jal/jalr/store 4; load 5.
- instret wraps modulo 2^W.
- Reset asserted mid-instruction aborts immediately: no partial strobe is issued after reset rises.

Decomposition:
- Package ctrl_pkg:
  - state enum;
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_SYSTEM);
  - ALUctl, PCsrc and MemtoReg encodings.
- One combinational sub-module, alu_decoder: (opcode, funct3, funct7b5) -> ALUctl, is_slt.

Test Plan:
- Reset, run=1, IR=add (0x00000033) -> FETCH/DECODE/EXEC/WB. ALUctl=000, ALUsrc=0, RegWrite=1 and PCwrite=1 in cycle 4 only; instret=1.
- sub 0x40000033 -> ALUctl=001. srai 0x40005013 -> ALUctl=111, ALUsrc=1. addi with instr[30]=1 -> ALUctl=000.
- lw 0x00002003 -> 5 cycles, MemSize=10, MemtoReg=001 in WB. sb 0x00000023 -> MemWrite=1 for one cycle, MemSize=00, RegWrite never 1.
- beq with ALUzero=1 -> PCsrc=01 in EXEC. Same with ALUzero=0 -> PCsrc=00. bge with ALUneg=1 -> PCsrc=00. Each takes 3 cycles.
- jal 0x0000006F -> MemtoReg=010, PCsrc=01 in WB. jalr 0x00000067 -> PCsrc=10. lui -> MemtoReg=011. slt -> MemtoReg=101.
- ebreak 0x00100073 -> halted=1, no PCwrite, instret unchanged. Opcode 0x7F -> halted=1, illegal=1. Drop run -> IDLE, illegal=0. Assert rst mid-MEM -> all outputs zero asynchronously.
